// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives start/bin; the slave (converter) returns status and digits.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       bcd3;
  logic [3:0]       bcd2;
  logic [3:0]       bcd1;
  logic [3:0]       bcd0;

  modport master (
    output start, bin,
    input  busy, done, ovf, bcd3, bcd2, bcd1, bcd0
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, bcd3, bcd2, bcd1, bcd0
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per clock, BIN_W+1 cycles per
// conversion, results saturate to 9999 with ovf when the input exceeds four digits.

// Per-digit correction applied before each shift.
module bin2bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);
  localparam int DIGITS = 4;
  localparam int MAXVAL = 9999;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [BIN_W-1:0]         sh_q, sh_d;
  logic [DIGITS-1:0][3:0]   dg_q, dg_d, dg_adj;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovfn_q, ovfn_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;
  logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic                     bin_big;

  assign bin_big = 32'(bus.bin) > 32'(MAXVAL);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_digit_adj u_adj (
      .din  (dg_q[g]),
      .dout (dg_adj[g])
    );
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dg_d    = dg_q;
    cnt_d   = cnt_q;
    ovfn_d  = ovfn_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin;
          dg_d    = '0;
          cnt_d   = '0;
          ovfn_d  = bin_big;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Digits beyond the fourth fall off the top; only overflow inputs reach them.
        {dg_d, sh_d} = {dg_adj, sh_q} << 1;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        bcd_d   = ovfn_q ? {DIGITS{4'd9}} : dg_q;
        ovf_d   = ovfn_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dg_q    <= '0;
      cnt_q   <= '0;
      ovfn_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dg_q    <= dg_d;
      cnt_q   <= cnt_d;
      ovfn_q  <= ovfn_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.bcd3 = bcd_q[3];
  assign bus.bcd2 = bcd_q[2];
  assign bus.bcd1 = bcd_q[1];
  assign bus.bcd0 = bcd_q[0];
endmodule
